// File: rtl/orbit_tx_scheduler.sv
// Orbit phase counter driving per-channel TX enable windows, with continuous or N-orbit one-shot runs.
// Config is double-buffered: shadows load into active regs in IDLE and at each orbit boundary.
module orbit_tx_scheduler #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 16,
   parameter int ORB_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cntr_enable,
   input  logic                 mode_oneshot,
   input  logic [ORB_WIDTH-1:0] num_orbits,
   input  logic                 cfg_wr,
   input  logic [4:0]           cfg_sel,
   input  logic [CNT_WIDTH-1:0] cfg_offset,
   input  logic [CNT_WIDTH-1:0] cfg_len,
   output logic [CHANNELS-1:0]  tx_enable,
   output logic                 orbit_tick,
   output logic [CNT_WIDTH-1:0] phase,
   output logic [ORB_WIDTH-1:0] orbit_count,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   phase_q, phase_d;
   logic [ORB_WIDTH-1:0]   orb_q, orb_d;
   logic                   oneshot_q, oneshot_d;
   logic [ORB_WIDTH-1:0]   num_q, num_d;
   logic [CHANNELS-1:0]    tx_q, tx_d;
   logic                   tick_q, tick_d;
   logic                   busy_q, busy_d;

   logic [CNT_WIDTH-1:0]   sh_per_q, act_per_q, nx_per;
   logic [CNT_WIDTH-1:0]   sh_off_q  [CHANNELS];
   logic [CNT_WIDTH-1:0]   sh_len_q  [CHANNELS];
   logic [CNT_WIDTH-1:0]   act_off_q [CHANNELS];
   logic [CNT_WIDTH-1:0]   act_len_q [CHANNELS];
   logic [CNT_WIDTH-1:0]   nx_off    [CHANNELS];
   logic [CNT_WIDTH-1:0]   nx_len    [CHANNELS];

   logic [CNT_WIDTH-1:0]   per_act, per_nx;
   logic                   boundary, load, run_nx;

   always_comb begin
      per_act  = (act_per_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : act_per_q;
      boundary = (state_q != IDLE) && (phase_q == per_act - CNT_WIDTH'(1));
      load     = (state_q == IDLE) || boundary;
      // Outputs are registered, so the next cycle's window must use the config it will see.
      nx_per   = load ? sh_per_q : act_per_q;
      per_nx   = (nx_per < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : nx_per;
      for (int i = 0; i < CHANNELS; i++) begin
         nx_off[i] = load ? sh_off_q[i] : act_off_q[i];
         nx_len[i] = load ? sh_len_q[i] : act_len_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      orb_d     = orb_q;
      oneshot_d = oneshot_q;
      num_d     = num_q;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (cntr_enable) begin
               state_d   = RUN;
               orb_d     = '0;
               oneshot_d = mode_oneshot;
               num_d     = (num_orbits == '0) ? ORB_WIDTH'(1) : num_orbits;
            end
         end
         default: begin
            if (boundary) begin
               phase_d = '0;
               orb_d   = orb_q + ORB_WIDTH'(1);
               if (!cntr_enable || (oneshot_q && (orb_d == num_q)))
                  state_d = IDLE;
               else
                  state_d = RUN;
            end else begin
               phase_d = phase_q + CNT_WIDTH'(1);
               state_d = cntr_enable ? RUN : DRAIN;
            end
         end
      endcase

      run_nx = (state_d != IDLE);
      busy_d = run_nx;
      tick_d = run_nx && (phase_d == per_nx - CNT_WIDTH'(1));
      for (int i = 0; i < CHANNELS; i++) begin
         // Window end is summed one bit wider so offset+len never wraps.
         tx_d[i] = run_nx && (nx_off[i] <= phase_d) &&
                   ({1'b0, phase_d} < ({1'b0, nx_off[i]} + {1'b0, nx_len[i]}));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         orb_q     <= '0;
         oneshot_q <= 1'b0;
         num_q     <= '0;
         tx_q      <= '0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         sh_per_q  <= '1;
         act_per_q <= '1;
         for (int i = 0; i < CHANNELS; i++) begin
            sh_off_q[i]  <= '0;
            sh_len_q[i]  <= '0;
            act_off_q[i] <= '0;
            act_len_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         orb_q     <= orb_d;
         oneshot_q <= oneshot_d;
         num_q     <= num_d;
         tx_q      <= tx_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
         act_per_q <= nx_per;
         if (cfg_wr && (cfg_sel == 5'd31))
            sh_per_q <= cfg_offset;
         for (int i = 0; i < CHANNELS; i++) begin
            act_off_q[i] <= nx_off[i];
            act_len_q[i] <= nx_len[i];
            if (cfg_wr && (cfg_sel == 5'(i))) begin
               sh_off_q[i] <= cfg_offset;
               sh_len_q[i] <= cfg_len;
            end
         end
      end
   end

   assign tx_enable   = tx_q;
   assign orbit_tick  = tick_q;
   assign phase       = phase_q;
   assign orbit_count = orb_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_orbit_tx_scheduler.sv
// Directed bench for orbit_tx_scheduler: windows, clipping, double buffering, one-shot, drain, reset.
module tb_orbit_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        cntr_enable;
   logic        mode_oneshot;
   logic [7:0]  num_orbits;
   logic        cfg_wr;
   logic [4:0]  cfg_sel;
   logic [15:0] cfg_offset;
   logic [15:0] cfg_len;
   logic [3:0]  tx_enable;
   logic        orbit_tick;
   logic [15:0] phase;
   logic [7:0]  orbit_count;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   orbit_tx_scheduler #(.CHANNELS(4), .CNT_WIDTH(16), .ORB_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cntr_enable  (cntr_enable),
      .mode_oneshot (mode_oneshot),
      .num_orbits   (num_orbits),
      .cfg_wr       (cfg_wr),
      .cfg_sel      (cfg_sel),
      .cfg_offset   (cfg_offset),
      .cfg_len      (cfg_len),
      .tx_enable    (tx_enable),
      .orbit_tick   (orbit_tick),
      .phase        (phase),
      .orbit_count  (orbit_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int ph, input int tx, input int tick,
                            input int cnt, input int bsy);
      check({tag, " phase"}, 32'(phase), ph);
      check({tag, " tx"}, 32'(tx_enable), tx);
      check({tag, " tick"}, 32'(orbit_tick), tick);
      check({tag, " count"}, 32'(orbit_count), cnt);
      check({tag, " busy"}, 32'(busy), bsy);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [4:0] s, input int o, input int l);
      cfg_sel    = s;
      cfg_offset = 16'(o);
      cfg_len    = 16'(l);
      cfg_wr     = 1'b1;
      step();
      cfg_wr     = 1'b0;
   endtask

   initial begin
      int ph, tx, lo, hi, o;
      reset = 1'b1; cntr_enable = 1'b0; mode_oneshot = 1'b0; num_orbits = 8'd0;
      cfg_wr = 1'b0; cfg_sel = '0; cfg_offset = '0; cfg_len = '0;
      step(); step();
      check_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      step();

      // Basic windows: period 10, ch0 [2,5), ch1 always on
      cfg(5'd31, 10, 0); cfg(5'd0, 2, 3); cfg(5'd1, 0, 10);
      cntr_enable = 1'b1;
      for (int j = 0; j < 30; j++) begin
         step();
         ph = j % 10;
         tx = 2 | ((ph >= 2 && ph <= 4) ? 1 : 0);
         check_all($sformatf("basic j%0d", j), ph, tx, (ph == 9) ? 1 : 0, j / 10, 1);
         if (j == 29) cntr_enable = 1'b0;
      end
      step();
      check_all("boundary_stop", 0, 0, 0, 3, 0);

      // Clipping and degenerate windows at period 8
      cfg(5'd31, 8, 0); cfg(5'd2, 6, 5); cfg(5'd3, 2, 0); cfg(5'd0, 9, 4); cfg(5'd1, 0, 0);
      cntr_enable = 1'b1;
      for (int j = 0; j < 16; j++) begin
         step();
         ph = j % 8;
         tx = (ph == 6 || ph == 7) ? 4 : 0;
         check_all($sformatf("clip j%0d", j), ph, tx, (ph == 7) ? 1 : 0, j / 8, 1);
         if (j == 15) cntr_enable = 1'b0;
      end
      step();
      cfg(5'd31, 1, 0);
      cntr_enable = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         ph = j % 2;
         check_all($sformatf("per1 j%0d", j), ph, 0, (ph == 1) ? 1 : 0, j / 2, 1);
         if (j == 5) cntr_enable = 1'b0;
      end
      step();

      // Double buffering: mid-orbit write, then a write in the tick cycle
      cfg(5'd31, 10, 0); cfg(5'd2, 0, 0); cfg(5'd0, 2, 3);
      cntr_enable = 1'b1;
      for (int j = 0; j < 40; j++) begin
         step();
         ph = j % 10;
         o  = j / 10;
         lo = (o == 0) ? 2 : (o <= 2) ? 5 : 0;
         hi = (o == 0) ? 5 : (o <= 2) ? 8 : 2;
         check($sformatf("dbuf tx j%0d", j), 32'(tx_enable), (ph >= lo && ph < hi) ? 1 : 0);
         check($sformatf("dbuf phase j%0d", j), 32'(phase), ph);
         cfg_wr     = (j == 3 || j == 19);
         cfg_sel    = 5'd0;
         cfg_offset = (j == 3) ? 16'd5 : 16'd0;
         cfg_len    = (j == 3) ? 16'd3 : 16'd2;
         if (j == 39) cntr_enable = 1'b0;
      end
      cfg_wr = 1'b0;
      step();

      // One-shot: 3 orbits of period 4; mode/num changed after start must be ignored
      cfg(5'd31, 4, 0);
      mode_oneshot = 1'b1; num_orbits = 8'd3; cntr_enable = 1'b1;
      for (int j = 0; j < 13; j++) begin
         step();
         ph = j % 4;
         if (j < 12)
            check_all($sformatf("os3 j%0d", j), ph, (ph < 2) ? 1 : 0, (ph == 3) ? 1 : 0, j / 4, 1);
         else
            check_all("os3 end", 0, 0, 0, 3, 0);
         if (j == 0) begin mode_oneshot = 1'b0; num_orbits = 8'd1; end
         if (j == 12) cntr_enable = 1'b0;
      end
      mode_oneshot = 1'b1; num_orbits = 8'd0; cntr_enable = 1'b1;
      for (int j = 0; j < 5; j++) begin
         step();
         if (j < 4)
            check_all($sformatf("os0 j%0d", j), j, (j < 2) ? 1 : 0, (j == 3) ? 1 : 0, 0, 1);
         else
            check_all("os0 end", 0, 0, 0, 1, 0);
         if (j == 4) cntr_enable = 1'b0;
      end
      mode_oneshot = 1'b0;

      // Drain: drop at phase 4, orbit finishes then IDLE
      cfg(5'd31, 10, 0);
      cntr_enable = 1'b1;
      for (int j = 0; j < 11; j++) begin
         step();
         if (j < 10)
            check_all($sformatf("drain j%0d", j), j, (j < 2) ? 1 : 0, (j == 9) ? 1 : 0, 0, 1);
         else
            check_all("drain end", 0, 0, 0, 1, 0);
         if (j == 4) cntr_enable = 1'b0;
      end
      // Cancel: drop at phase 4, reassert at phase 6, run continues undisturbed
      cntr_enable = 1'b1;
      for (int j = 0; j < 30; j++) begin
         step();
         check($sformatf("cancel busy j%0d", j), 32'(busy), 1);
         check($sformatf("cancel phase j%0d", j), 32'(phase), j % 10);
         if (j == 4) cntr_enable = 1'b0;
         if (j == 6) cntr_enable = 1'b1;
         if (j == 29) cntr_enable = 1'b0;
      end
      step();
      check("cancel end busy", 32'(busy), 0);

      // Reset mid-run at orbit 1 phase 5
      cntr_enable = 1'b1;
      for (int j = 0; j < 16; j++) step();
      check("pre_reset count", 32'(orbit_count), 1);
      reset = 1'b1;
      step();
      check_all("mid_reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      for (int j = 0; j < 25; j++) begin
         step();
         check($sformatf("post_reset tx j%0d", j), 32'(tx_enable), 0);
         check($sformatf("post_reset phase j%0d", j), 32'(phase), j);
         check($sformatf("post_reset busy j%0d", j), 32'(busy), 1);
      end
      cntr_enable = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
